sisc_ifetch: RTL

Instruction-fetch and branch-resolution unit for the SISC multi-cycle processor. Holds the program counter, instruction register and status register. Decodes the instruction fields (opcode, mm, register indices, immediate) that the control FSM and the datapath consume. Runs a request/acknowledge handshake with instruction memory, and resolves BRA/BRR/BNE/BNR branches when the control FSM tells it to.

---
 rtl/sisc_pkg.sv | 38 +++
 rtl/sisc_br_cond.sv | 53 +++++
 rtl/sisc_ifetch.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC fetch/branch slice: opcodes, IR field
// positions, status flag indices and the fetch-state encoding.
package sisc_pkg;

  localparam logic [3:0] NOOP   = 4'h0;
  localparam logic [3:0] LOD    = 4'h1;
  localparam logic [3:0] STR    = 4'h2;
  localparam logic [3:0] SWP    = 4'h3;
  localparam logic [3:0] BRA    = 4'h4;
  localparam logic [3:0] BRR    = 4'h5;
  localparam logic [3:0] BNE    = 4'h6;
  localparam logic [3:0] BNR    = 4'h7;
  localparam logic [3:0] ALU_OP = 4'h8;
  localparam logic [3:0] HLT    = 4'hF;

  localparam int IR_OP_LO  = 28;
  localparam int IR_MM_LO  = 24;
  localparam int IR_RD_LO  = 20;
  localparam int IR_RS_LO  = 16;
  localparam int IR_RT_LO  = 12;
  localparam int IR_IMM_LO = 0;

  localparam int STAT_C = 3;
  localparam int STAT_N = 2;
  localparam int STAT_V = 1;
  localparam int STAT_Z = 0;

  typedef enum logic [0:0] {
    FETCH_IDLE = 1'b0,
    FETCH_REQ  = 1'b1
  } fetch_state_e;

  // A branch condition matches when any flag selected by the mask is set.
  function automatic logic cond_hit(input logic [3:0] mask, input logic [3:0] flags);
    return |(mask & flags);
  endfunction

endpackage

// File: rtl/sisc_br_cond.sv
// Combinational branch resolution: decides taken and computes the new PC
// for absolute (BRA/BNE) and PC-relative (BRR/BNR) branches.
module sisc_br_cond
  import sisc_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic [3:0]      opcode,
  input  logic [3:0]      mm,
  input  logic [3:0]      stat,
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     imm,
  output logic            taken,
  output logic [PC_W-1:0] target
);

  logic            hit_s;
  logic [PC_W-1:0] imm_abs_s;
  logic [PC_W-1:0] imm_sext_s;

  assign hit_s      = cond_hit(mm, stat);
  assign imm_abs_s  = PC_W'(imm);
  assign imm_sext_s = PC_W'($signed(imm));

  // Select condition sense and target form from the opcode.
  always_comb begin
    taken  = 1'b0;
    target = pc;
    case (opcode)
      BRA: begin
        taken  = hit_s;
        target = imm_abs_s;
      end
      BRR: begin
        taken  = hit_s;
        target = pc + imm_sext_s;
      end
      BNE: begin
        taken  = ~hit_s;
        target = imm_abs_s;
      end
      BNR: begin
        taken  = ~hit_s;
        target = pc + imm_sext_s;
      end
      default: begin
        taken  = 1'b0;
        target = pc;
      end
    endcase
  end

endmodule

// File: rtl/sisc_ifetch.sv
// SISC instruction fetch unit: PC, IR and status registers, the memory
// request/acknowledge handshake and branch resolution on br_eval.
module sisc_ifetch
  import sisc_pkg::*;
#(
  parameter int PC_W = 16,
  parameter int IW   = 32
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            fetch_start,
  input  logic            br_eval,
  input  logic            stat_en,
  input  logic [3:0]      stat_in,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [IW-1:0]   imem_data,
  output logic [3:0]      opcode,
  output logic [3:0]      mm,
  output logic [3:0]      rd,
  output logic [3:0]      rs,
  output logic [3:0]      rt,
  output logic [15:0]     imm,
  output logic [3:0]      stat,
  output logic [PC_W-1:0] pc,
  output logic            ir_valid,
  output logic            busy,
  output logic            br_taken
);

  fetch_state_e    state_r;
  fetch_state_e    state_nxt_s;
  logic [IW-1:0]   ir_r;
  logic [PC_W-1:0] pc_r;
  logic [3:0]      stat_r;
  logic            ir_valid_r;
  logic            busy_r;
  logic            req_r;
  logic            br_taken_r;
  logic            ack_take_s;
  logic            br_take_s;
  logic            taken_s;
  logic [PC_W-1:0] target_s;

  assign opcode    = ir_r[IR_OP_LO +: 4];
  assign mm        = ir_r[IR_MM_LO +: 4];
  assign rd        = ir_r[IR_RD_LO +: 4];
  assign rs        = ir_r[IR_RS_LO +: 4];
  assign rt        = ir_r[IR_RT_LO +: 4];
  assign imm       = ir_r[IR_IMM_LO +: 16];
  assign stat      = stat_r;
  assign pc        = pc_r;
  assign imem_addr = pc_r;
  assign imem_req  = req_r;
  assign busy      = busy_r;
  assign ir_valid  = ir_valid_r;
  assign br_taken  = br_taken_r;

  sisc_br_cond #(.PC_W(PC_W)) u_br_cond (
    .opcode (opcode),
    .mm     (mm),
    .stat   (stat_r),
    .pc     (pc_r),
    .imm    (imm),
    .taken  (taken_s),
    .target (target_s)
  );

  // Fetch state register.
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state_r <= FETCH_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state; branches are only accepted while no fetch is outstanding.
  always_comb begin
    state_nxt_s = state_r;
    ack_take_s  = 1'b0;
    br_take_s   = 1'b0;
    case (state_r)
      FETCH_IDLE: begin
        br_take_s = br_eval;
        if (fetch_start) begin
          state_nxt_s = FETCH_REQ;
        end else begin
          state_nxt_s = FETCH_IDLE;
        end
      end
      FETCH_REQ: begin
        ack_take_s = imem_ack;
        if (imem_ack) begin
          state_nxt_s = FETCH_IDLE;
        end else begin
          state_nxt_s = FETCH_REQ;
        end
      end
      default: begin
        state_nxt_s = FETCH_IDLE;
      end
    endcase
  end

  // Architectural registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      ir_r       <= '0;
      pc_r       <= '0;
      stat_r     <= 4'h0;
      ir_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      req_r      <= 1'b0;
      br_taken_r <= 1'b0;
    end else begin
      ir_valid_r <= ack_take_s;
      req_r      <= (state_nxt_s == FETCH_REQ);
      busy_r     <= (state_nxt_s == FETCH_REQ);
      if (stat_en) begin
        stat_r <= stat_in;
      end
      if (ack_take_s) begin
        ir_r <= imem_data;
        pc_r <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
      end else if (br_take_s && taken_s) begin
        pc_r <= target_s;
      end
      if (br_take_s) begin
        br_taken_r <= taken_s;
      end
    end
  end

endmodule
